// File: rtl/rotate_sequencer_pkg.sv
// Shared definitions for the rotate sequencer.
// Contents: FSM state encoding, axis/turns command encodings, alu opcode
// constants, and the orientation limit used to validate transformed pieces.
package rotate_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] AXIS_RL   = 2'd0;
    localparam logic [1:0] AXIS_UD   = 2'd1;
    localparam logic [1:0] AXIS_FB   = 2'd2;
    localparam logic [1:0] AXIS_RSVD = 2'd3;

    localparam logic [1:0] TURNS_0   = 2'd0;
    localparam logic [1:0] TURNS_90  = 2'd1;
    localparam logic [1:0] TURNS_180 = 2'd2;
    localparam logic [1:0] TURNS_270 = 2'd3;

    localparam logic [4:0] OP_NOP    = 5'h00;
    localparam logic [4:0] OP_RL_90  = 5'h01;
    localparam logic [4:0] OP_RL_180 = 5'h02;
    localparam logic [4:0] OP_RL_270 = 5'h03;
    localparam logic [4:0] OP_UD_90  = 5'h04;
    localparam logic [4:0] OP_UD_180 = 5'h05;
    localparam logic [4:0] OP_UD_270 = 5'h06;
    localparam logic [4:0] OP_FB_90  = 5'h07;
    localparam logic [4:0] OP_FB_180 = 5'h08;
    localparam logic [4:0] OP_FB_270 = 5'h09;

    localparam logic [2:0] ORIENT_MAX = 3'd5;

    // A piece is {pos[7:3], orient[2:0]}; orientations 6 and 7 do not exist.
    function automatic logic orient_ok(input logic [7:0] piece);
        return piece[2:0] <= ORIENT_MAX;
    endfunction

endpackage

// File: rtl/rotate_sequencer_op_lut.sv
// Combinational rotation-opcode lookup.
// Ports:
//   axis    in  2  0=RL 1=UD 2=FB 3=reserved
//   turns   in  2  0=none 1=90 2=180 3=270
//   op      out 5  alu opcode (OP_NOP when turns=0 or illegal)
//   illegal out 1  reserved axis combined with a non-zero turn count
module rotate_sequencer_op_lut
    import rotate_sequencer_pkg::*;
(
    input  logic [1:0] axis,
    input  logic [1:0] turns,
    output logic [4:0] op,
    output logic       illegal
);

    always_comb begin
        op      = OP_NOP;
        illegal = 1'b0;
        case (axis)
            AXIS_RL: begin
                case (turns)
                    TURNS_90:  op = OP_RL_90;
                    TURNS_180: op = OP_RL_180;
                    TURNS_270: op = OP_RL_270;
                    default:   op = OP_NOP;
                endcase
            end
            AXIS_UD: begin
                case (turns)
                    TURNS_90:  op = OP_UD_90;
                    TURNS_180: op = OP_UD_180;
                    TURNS_270: op = OP_UD_270;
                    default:   op = OP_NOP;
                endcase
            end
            AXIS_FB: begin
                case (turns)
                    TURNS_90:  op = OP_FB_90;
                    TURNS_180: op = OP_FB_180;
                    TURNS_270: op = OP_FB_270;
                    default:   op = OP_NOP;
                endcase
            end
            AXIS_RSVD: illegal = (turns != TURNS_0);
            default:   illegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rotate_sequencer.sv
// Sequences one cube-rotation command over the piece register file.
// Each masked piece is read (sync-read RAM), transformed by the external alu,
// and written back; unmasked pieces cost one scan cycle each.
// Ports:
//   clk, rst                 clock, async active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_axis/turns/mask      command fields
//   rf_addr/rf_rdata         piece read port (data valid the cycle after addr)
//   rf_we/rf_wdata           piece write port (address shared with rf_addr)
//   alu_op/alu_in0/alu_in1   alu operands, zero outside EXEC
//   alu_out                  combinational alu result
//   busy/done/err            status: in progress, completion pulse, sticky error
module rotate_sequencer
    import rotate_sequencer_pkg::*;
#(
    parameter int NPIECE = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_axis,
    input  logic [1:0]        cmd_turns,
    input  logic [NPIECE-1:0] cmd_mask,
    output logic [AW-1:0]     rf_addr,
    input  logic [7:0]        rf_rdata,
    output logic              rf_we,
    output logic [7:0]        rf_wdata,
    output logic [4:0]        alu_op,
    output logic [7:0]        alu_in0,
    output logic [7:0]        alu_in1,
    input  logic [7:0]        alu_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NPIECE - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [NPIECE-1:0] mask_q, mask_d;
    logic [4:0]        op_q, op_d;
    logic [7:0]        wbuf_q, wbuf_d;
    logic              ovld_q, ovld_d;
    logic              err_q, err_d;

    logic [4:0]        lut_op;
    logic              lut_illegal;

    rotate_sequencer_op_lut u_op_lut (
        .axis    (cmd_axis),
        .turns   (cmd_turns),
        .op      (lut_op),
        .illegal (lut_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            op_q    <= OP_NOP;
            wbuf_q  <= '0;
            ovld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            op_q    <= op_d;
            wbuf_q  <= wbuf_d;
            ovld_q  <= ovld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        op_d      = op_q;
        wbuf_d    = wbuf_q;
        ovld_d    = ovld_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        alu_op    = OP_NOP;
        alu_in0   = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    mask_d = cmd_mask;
                    op_d   = lut_op;
                    idx_d  = '0;
                    err_d  = lut_illegal;
                    // Nothing to rotate: skip the scan entirely.
                    if (lut_illegal || cmd_turns == TURNS_0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (mask_q[idx_q]) begin
                    state_d = ST_EXEC;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_EXEC: begin
                // rf_rdata now holds the piece addressed during SCAN.
                alu_op  = op_q;
                alu_in0 = rf_rdata;
                wbuf_d  = alu_out;
                ovld_d  = orient_ok(alu_out);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (ovld_q) begin
                    rf_we    = 1'b1;
                    rf_wdata = wbuf_q;
                end else begin
                    err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rf_addr = idx_q;
    assign alu_in1 = '0;
    assign err     = err_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
module tb_rotate_sequencer;
    import rotate_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_axis = 2'd0;
    logic [1:0] cmd_turns = 2'd0;
    logic [7:0] cmd_mask = 8'd0;
    logic [2:0] rf_addr;
    logic [7:0] rf_rdata = 8'd0;
    logic       rf_we;
    logic [7:0] rf_wdata;
    logic [4:0] alu_op;
    logic [7:0] alu_in0;
    logic [7:0] alu_in1;
    logic [7:0] alu_out;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [8];
    logic       tb_wr = 1'b0;
    logic [2:0] tb_waddr = 3'd0;
    logic [7:0] tb_wdata = 8'd0;
    int         we_cnt = 0;
    int         op_cnt = 0;
    int         acc_cnt = 0;
    logic [4:0] last_op = 5'd0;

    always #5 clk = ~clk;

    rotate_sequencer #(.NPIECE(8), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_axis  (cmd_axis),
        .cmd_turns (cmd_turns),
        .cmd_mask  (cmd_mask),
        .rf_addr   (rf_addr),
        .rf_rdata  (rf_rdata),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .alu_op    (alu_op),
        .alu_in0   (alu_in0),
        .alu_in1   (alu_in1),
        .alu_out   (alu_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Piece register file: synchronous read, DUT write port has priority.
    always @(posedge clk) begin
        rf_rdata <= mem[rf_addr];
        if (rf_we) mem[rf_addr] <= rf_wdata;
        else if (tb_wr) mem[tb_waddr] <= tb_wdata;
    end

    // Event monitors.
    always @(posedge clk) begin
        if (rf_we) we_cnt <= we_cnt + 1;
        if (alu_op != 5'd0) begin
            op_cnt  <= op_cnt + 1;
            last_op <= alu_op;
        end
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    // Stand-in alu: known transforms for the directed pieces, identity otherwise.
    function automatic logic [7:0] alu_model(input logic [4:0] op, input logic [7:0] in0);
        if (op == OP_RL_90  && in0 == 8'h08) return 8'h0A;
        if (op == OP_RL_90  && in0 == 8'h12) return 8'h15;
        if (op == OP_UD_270 && in0 == 8'h21) return 8'h20;
        return in0;
    endfunction

    assign alu_out = alu_model(alu_op, alu_in0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_waddr = a;
        tb_wdata = d;
        tb_wr    = 1'b1;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    // Issue one command and return cycles from the accept edge to the done sample.
    task automatic run_cmd(input logic [1:0] ax, input logic [1:0] tn,
                           input logic [7:0] mk, output int lat);
        @(negedge clk);
        cmd_axis  = ax;
        cmd_turns = tn;
        cmd_mask  = mk;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int we0;
        int op0;
        int acc0;

        // Reset values
        #1;
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_we", rf_we, 1'b0);
        check("rst_addr", rf_addr, 3'd0);
        check("rst_wdata", rf_wdata, 8'd0);
        check("rst_op", alu_op, 5'd0);
        check("rst_in0", alu_in0, 8'd0);
        check("rst_in1", alu_in1, 8'd0);

        for (int i = 0; i < 8; i++) preload(3'(i), 8'hA0 + 8'(i));
        preload(3'd0, 8'h08);
        preload(3'd1, 8'h07);
        preload(3'd2, 8'h12);
        preload(3'd7, 8'h21);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted during WRITE aborts without writing
        @(negedge clk);
        cmd_axis = AXIS_RL; cmd_turns = TURNS_90; cmd_mask = 8'h01; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t1_exec_op", alu_op, OP_RL_90);
        check("t1_exec_in0", alu_in0, 8'h08);
        @(negedge clk);
        check("t1_write_we", rf_we, 1'b1);
        check("t1_write_data", rf_wdata, 8'h0A);
        rst = 1'b1;
        #1;
        check("t1_async_we", rf_we, 1'b0);
        check("t1_async_ready", cmd_ready, 1'b1);
        check("t1_async_busy", busy, 1'b0);
        check("t1_async_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("t1_rf0_kept", mem[0], 8'h08);

        // RL_90 on pieces 0 and 2
        we0 = we_cnt;
        run_cmd(AXIS_RL, TURNS_90, 8'h05, lat);
        check("t2_latency", lat, 13);
        check("t2_done_busy", busy, 1'b1);
        check("t2_err", err, 1'b0);
        check("t2_op", last_op, OP_RL_90);
        check("t2_rf0", mem[0], 8'h0A);
        check("t2_rf2", mem[2], 8'h15);
        check("t2_rf1", mem[1], 8'h07);
        check("t2_writes", we_cnt - we0, 2);
        check_idle_after("t2");

        // UD_270 on piece 7 only
        we0 = we_cnt;
        run_cmd(AXIS_UD, TURNS_270, 8'h80, lat);
        check("t3_latency", lat, 11);
        check("t3_op", last_op, OP_UD_270);
        check("t3_rf7", mem[7], 8'h20);
        check("t3_writes", we_cnt - we0, 1);
        check("t3_err", err, 1'b0);
        check_idle_after("t3");

        // Reserved axis
        we0 = we_cnt;
        op0 = op_cnt;
        run_cmd(AXIS_RSVD, TURNS_180, 8'hFF, lat);
        check("t5a_latency", lat, 1);
        check("t5a_err", err, 1'b1);
        check("t5a_writes", we_cnt - we0, 0);
        check("t5a_alu_idle", op_cnt - op0, 0);
        check_idle_after("t5a");
        check("t5a_err_sticky", err, 1'b1);

        // Zero turns: done next cycle, accept clears the earlier error
        we0 = we_cnt;
        op0 = op_cnt;
        run_cmd(AXIS_RL, TURNS_0, 8'hFF, lat);
        check("t4a_latency", lat, 1);
        check("t4a_err", err, 1'b0);
        check("t4a_writes", we_cnt - we0, 0);
        check("t4a_alu_idle", op_cnt - op0, 0);
        check_idle_after("t4a");

        // Empty mask: full scan, no writes
        we0 = we_cnt;
        op0 = op_cnt;
        run_cmd(AXIS_FB, TURNS_90, 8'h00, lat);
        check("t4b_latency", lat, 9);
        check("t4b_err", err, 1'b0);
        check("t4b_writes", we_cnt - we0, 0);
        check("t4b_alu_idle", op_cnt - op0, 0);
        check("t4b_last_addr", rf_addr, 3'd7);
        check_idle_after("t4b");

        // Invalid orientation after transform: error, piece untouched
        we0 = we_cnt;
        run_cmd(AXIS_RL, TURNS_90, 8'h02, lat);
        check("t5b_latency", lat, 11);
        check("t5b_err", err, 1'b1);
        check("t5b_rf1", mem[1], 8'h07);
        check("t5b_writes", we_cnt - we0, 0);
        check_idle_after("t5b");

        // cmd_valid held high: one accept per IDLE visit
        @(negedge clk);
        cmd_axis = AXIS_RL; cmd_turns = TURNS_0; cmd_mask = 8'h00; cmd_valid = 1'b1;
        acc0 = acc_cnt;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_ready_%0d", k), cmd_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("t6_done_%0d", k), done, (k % 2 == 1) ? 1'b1 : 1'b0);
        end
        check("t6_accepts", acc_cnt - acc0, 4);
        // Now IDLE with valid high; a long command must not be re-accepted while busy
        cmd_turns = TURNS_90; cmd_mask = 8'h01;
        acc0 = acc_cnt;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("t6_long_latency", lat, 11);
        check("t6_long_accepts", acc_cnt - acc0, 1);
        check("t6_rf0", mem[0], 8'h0A);
        check_idle_after("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
